// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per rising edge of uart_transmit onto uart_txd.
// Frame is start bit, 8 data bits LSB first, then STOP_BITS stop bits.
// uart_txd_done is a level: high while idle, low while a frame is on the wire.

module uart_tx #(
  parameter int CLKS_PER_BIT = 434,  // clk cycles per bit, >= 2
  parameter int STOP_BITS    = 1     // 1 or 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_txd_data,
  input  logic       uart_transmit,
  output logic       uart_txd,
  output logic       uart_txd_done
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e              state_q;
  logic                xmit_q;
  logic [2:0]          bit_cnt_q;
  logic [STOP_W-1:0]   stop_cnt_q;
  logic [CNT_W-1:0]    clk_cnt_q;
  logic [7:0]          shift_q;
  logic                txd_q;
  logic                done_q;

  logic                start;
  logic                bit_end;

  // A frame starts only on a 0->1 request edge seen while idle; busy edges are dropped.
  assign start   = uart_transmit & ~xmit_q & (state_q == IDLE);
  assign bit_end = (clk_cnt_q == CNT_LAST);

  assign uart_txd      = txd_q;
  assign uart_txd_done = done_q;

  // Request edge detector: remembers last cycle's request level.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values, so ordering inside the block does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xmit_q <= 1'b0;
    end else begin
      xmit_q <= uart_transmit;
    end
  end

  // Frame sequencer with registered line and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset forces the line idle-high and done high immediately, abandoning any partial frame.
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      clk_cnt_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      done_q     <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          txd_q  <= 1'b1;
          done_q <= 1'b1;
          if (start) begin
            shift_q   <= uart_txd_data;
            clk_cnt_q <= '0;
            txd_q     <= 1'b0;
            done_q    <= 1'b0;
            state_q   <= START;
          end
        end

        START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            txd_q     <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              txd_q      <= 1'b1;
              stop_cnt_q <= '0;
              state_q    <= STOP;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          txd_q <= 1'b1;
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (stop_cnt_q == STOP_LAST) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + STOP_W'(1);
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule
